// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin packet arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Requester-side and sink-side signals of the arbiter, bundled as one port.
interface rr_mux8_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DW = 8
);

  logic                   en;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*DW-1:0]    data;
  logic [N_REQ-1:0]       last;
  logic [N_REQ-1:0]       ack;
  logic [N_REQ-1:0]       gnt;
  logic [SEL_W-1:0]       sel;
  logic                   busy;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic                   out_last;
  logic                   out_ready;

  // The arbiter itself.
  modport slave (
    input  en, req, data, last, out_ready,
    output ack, gnt, sel, busy, out_valid, out_data, out_last
  );

  // Sources plus sink, as seen from outside the arbiter.
  modport master (
    output en, req, data, last, out_ready,
    input  ack, gnt, sel, busy, out_valid, out_data, out_last
  );

endinterface

// File: rtl/rr_mux8_arbiter_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping 7 -> 0.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr lands on bit 0, find lowest set bit, then rotate back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    found = |rot;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// 8-way round-robin arbiter holding a grant for a whole packet and
// steering the granted requester onto a single valid/ready sink.
module rr_mux8_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input logic              clk,
  input logic              rst,
  rr_mux8_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, sel_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              busy_q;

  logic              found;
  logic [SEL_W-1:0]  pick_idx;
  logic              start, done;

  logic              valid_c, last_c;
  logic [DW-1:0]     data_c;
  logic [N_REQ-1:0]  ack_c;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign start = (state_q == IDLE) && bus.en && found;
  assign done  = valid_c && bus.out_ready && last_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave IDLE on a pick, return only when a last beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sink-side outputs and ack decode; everything is quiet outside BUSY.
  always_comb begin
    valid_c = 1'b0;
    last_c  = 1'b0;
    data_c  = '0;
    ack_c   = '0;
    if (state_q == BUSY) begin
      valid_c = bus.req[sel_q];
      last_c  = bus.last[sel_q];
      data_c  = bus.data[sel_q*DW +: DW];
      ack_c   = gnt_q & {N_REQ{valid_c & bus.out_ready}};
    end
  end

  // Grant bookkeeping: capture the pick on entry, advance ptr past the
  // finished requester on exit. sel keeps its last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sel_q  <= pick_idx;
      gnt_q  <= N_REQ'(1) << pick_idx;
      busy_q <= 1'b1;
    end else if (done) begin
      ptr_q  <= sel_q + SEL_W'(1);
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_c;
  assign bus.out_last  = last_c;
  assign bus.out_data  = data_c;
  assign bus.ack       = ack_c;
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: directed scenarios plus a
// randomized run compared against a packet-level reference model.
module tb_rr_mux8_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the channel (-1 = nobody), rotating pointer,
  // last selected index.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;

  rr_mux8_arbiter_if #(.DW(8)) bus ();

  rr_mux8_arbiter #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
  endtask

  // Evaluate the model on the inputs held since the last negedge, then
  // cross one rising edge and return on the following falling edge.
  task automatic advance();
    int nown, nptr, nsel;
    nown = m_owner;
    nptr = m_ptr;
    nsel = m_sel;
    if (m_owner < 0) begin
      if (bus.en && bus.req != 8'h00) begin
        nown = pick(bus.req, m_ptr);
        nsel = nown;
      end
    end else if (bus.req[m_owner] && bus.out_ready && bus.last[m_owner]) begin
      nptr = (m_owner + 1) % 8;
      nown = -1;
    end
    @(posedge clk);
    m_owner = nown;
    m_ptr   = nptr;
    m_sel   = nsel;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'($urandom);
    bus.req = 8'($urandom);
    bus.data = {$urandom, $urandom};
    bus.last = 8'($urandom);
    bus.out_ready = 1'($urandom);
    #1;
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL rst_gnt got %h exp 00", bus.gnt); end
    checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", bus.sel); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL rst_ack got %h exp 00", bus.ack); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", bus.out_data); end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    bus.en = 1'b1;
    bus.req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin errors++; $display("FAIL idle_after_rst busy %b gnt %h exp 0/00", bus.busy, bus.gnt); end
      advance();
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    bus.en = 1'b1;
    bus.req = 8'h08;
    bus.last = 8'h00;
    bus.out_ready = 1'b1;
    bus.data = {$urandom, $urandom};
    #1;
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL pkt_pre_gnt got %h exp 00", bus.gnt); end
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h08 || bus.sel !== 3'd3) begin errors++; $display("FAIL pkt_gnt got %h/%0d exp 08/3", bus.gnt, bus.sel); end
    checks++; if (bus.ack !== 8'h08) begin errors++; $display("FAIL pkt_ack1 got %h exp 08", bus.ack); end
    checks++; if (bus.out_data !== bus.data[31:24]) begin errors++; $display("FAIL pkt_data got %h exp %h", bus.out_data, bus.data[31:24]); end
    advance();
    bus.last = 8'h08;
    #1;
    checks++; if (bus.ack !== 8'h08 || bus.out_last !== 1'b1) begin errors++; $display("FAIL pkt_ack2 got %h last %b exp 08/1", bus.ack, bus.out_last); end
    advance();
    bus.req = 8'hFF;
    bus.last = 8'h00;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 8'h00) begin errors++; $display("FAIL pkt_bubble busy %b ack %h exp 0/00", bus.busy, bus.ack); end
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h10 || bus.sel !== 3'd4) begin errors++; $display("FAIL pkt_ptr4 got %h/%0d exp 10/4", bus.gnt, bus.sel); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.en = 1'b1;
    bus.req = 8'hFF;
    bus.last = 8'hFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d busy %b exp 0", i, bus.busy); end
      advance();
      #1;
      checks++; if (bus.gnt !== 8'(1 << (i % 8)) || bus.ack !== 8'(1 << (i % 8))) begin
        errors++; $display("FAIL rr_grant%0d gnt %h ack %h exp %h", i, bus.gnt, bus.ack, 8'(1 << (i % 8)));
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    apply_reset();
    d = {$urandom, $urandom};
    d[47:40] = 8'hA5;
    bus.data = d;
    bus.en = 1'b1;
    bus.req = 8'h20;
    bus.last = 8'h20;
    bus.out_ready = 1'b0;
    advance();
    bus.req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d data %h valid %b exp a5/1", i, bus.out_data, bus.out_valid); end
      checks++; if (bus.ack !== 8'h00 || bus.gnt !== 8'h20) begin errors++; $display("FAIL bp_stall%0d ack %h gnt %h exp 00/20", i, bus.ack, bus.gnt); end
      advance();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.ack !== 8'h20) begin errors++; $display("FAIL bp_accept ack %h exp 20", bus.ack); end
    advance();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_done busy %b exp 0", bus.busy); end
    advance();
  endtask

  task automatic test_wrap_and_enable();
    apply_reset();
    bus.en = 1'b1;
    bus.req = 8'h40;
    bus.last = 8'hFF;
    bus.out_ready = 1'b1;
    advance();
    advance();
    bus.req = 8'h81;
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h80) begin errors++; $display("FAIL wrap_first gnt %h exp 80", bus.gnt); end
    advance();
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h01) begin errors++; $display("FAIL wrap_second gnt %h exp 01", bus.gnt); end
    advance();
    bus.en = 1'b0;
    bus.req = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin errors++; $display("FAIL en_low%0d busy %b gnt %h exp 0/00", i, bus.busy, bus.gnt); end
      advance();
    end
    bus.en = 1'b1;
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h02) begin errors++; $display("FAIL en_high gnt %h exp 02", bus.gnt); end
    bus.last = 8'h00;
    bus.en = 1'b0;
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h02 || bus.ack !== 8'h02) begin errors++; $display("FAIL en_low_busy gnt %h ack %h exp 02/02", bus.gnt, bus.ack); end
    bus.last = 8'hFF;
    advance();
    advance();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_low_after busy %b exp 0", bus.busy); end
    bus.en = 1'b1;
    advance();
  endtask

  task automatic test_reset_midpacket();
    apply_reset();
    bus.en = 1'b1;
    bus.req = 8'h04;
    bus.last = 8'h00;
    bus.out_ready = 1'b1;
    advance();
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h04) begin errors++; $display("FAIL midrst_pre gnt %h exp 04", bus.gnt); end
    rst = 1'b1;
    #1;
    checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async gnt %h busy %b valid %b exp 00/0/0", bus.gnt, bus.busy, bus.out_valid);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 8'h05;
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h01) begin errors++; $display("FAIL midrst_ptr0 gnt %h exp 01", bus.gnt); end
    apply_reset();
    bus.req = 8'h04;
    advance();
    #1;
    checks++; if (bus.gnt !== 8'h04) begin errors++; $display("FAIL midrst_regrant gnt %h exp 04", bus.gnt); end
  endtask

  task automatic test_random();
    logic [7:0] e_gnt, e_ack;
    logic       e_valid, e_last;
    logic [7:0] e_data;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      bus.req = 8'($urandom);
      bus.data = {$urandom, $urandom};
      bus.last = 8'($urandom) & 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      e_valid = (m_owner >= 0) ? bus.req[m_owner] : 1'b0;
      e_last = (m_owner >= 0) ? bus.last[m_owner] : 1'b0;
      e_data = (m_owner >= 0) ? bus.data[m_owner*8 +: 8] : 8'h00;
      e_ack = (e_valid && bus.out_ready) ? e_gnt : 8'h00;
      checks++; if (bus.gnt !== e_gnt || bus.busy !== (m_owner >= 0) || bus.sel !== 3'(m_sel)) begin
        errors++; $display("FAIL rand_grant c%0d gnt %h busy %b sel %0d exp %h/%b/%0d", c, bus.gnt, bus.busy, bus.sel, e_gnt, (m_owner >= 0), m_sel);
      end
      checks++; if (bus.out_valid !== e_valid || bus.out_last !== e_last || bus.out_data !== e_data) begin
        errors++; $display("FAIL rand_sink c%0d v %b l %b d %h exp %b/%b/%h", c, bus.out_valid, bus.out_last, bus.out_data, e_valid, e_last, e_data);
      end
      checks++; if (bus.ack !== e_ack) begin errors++; $display("FAIL rand_ack c%0d got %h exp %h", c, bus.ack, e_ack); end
      advance();
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.req = 8'h00;
    bus.data = '0;
    bus.last = 8'h00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_wrap_and_enable();
    test_reset_midpacket();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
